md5_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares a single Wishbone-based MD5 core between two requesters, e.g. the AXI4-Lite bridge and a DMA/self-test engine. Grants are round-robin and locked for a whole bus cycle, so a multi-word message load and digest readback cannot interleave. The block sits between the masters and the MD5 core slave port, in the Wishbone clock domain.

---
 rtl/md5_arb_pkg.sv | 11 +
 rtl/md5_arb_timeout.sv | 30 +++
 rtl/md5_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_md5_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_arb_pkg.sv
// Shared types and constants for the two-master MD5 Wishbone arbiter.
package md5_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;

  typedef logic master_id_t;

  localparam int NUM_MASTERS     = 2;
  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/md5_arb_timeout.sv
// Stalled-strobe watchdog: counts unacknowledged strobe cycles and pulses expire
// combinationally on the TIMEOUT_CYCLES-th one; clear wins over counting.
module md5_arb_timeout
  import md5_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic clear,
  output logic expire
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;

  assign expire = stall && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/md5_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter for the MD5 core; grant registered (1 cycle), then
// combinational forwarding locked for a whole CYC; non-owner stalls. MD5_ARB_TIMEOUT_EN adds a watchdog.
module md5_wb_arbiter
  import md5_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                                     wb_clk_i,
  input  logic                                     wb_rst_i,
  input  logic [NUM_MASTERS-1:0]                   m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                   m_stb_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]        m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]        m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]    m_sel_i,
  output logic [DATA_WIDTH-1:0]                    m_dat_o,
  output logic [NUM_MASTERS-1:0]                   m_ack_o,
  output logic [NUM_MASTERS-1:0]                   m_err_o,
  output logic                                     s_cyc_o,
  output logic                                     s_stb_o,
  output logic                                     s_we_o,
  output logic [ADDR_WIDTH-1:0]                    s_adr_o,
  output logic [DATA_WIDTH-1:0]                    s_dat_o,
  output logic [DATA_WIDTH/8-1:0]                  s_sel_o,
  input  logic [DATA_WIDTH-1:0]                    s_dat_i,
  input  logic                                     s_ack_i,
  input  logic                                     s_err_i,
  output logic [NUM_MASTERS-1:0]                   grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  arb_state_t state;
  master_id_t owner;
  master_id_t last_owner;

  logic                   own;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   own_we;
  logic [ADDR_WIDTH-1:0]  own_adr;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic [SEL_WIDTH-1:0]   own_sel;
  logic [NUM_MASTERS-1:0] owner_mask;
  logic [NUM_MASTERS-1:0] req;
  logic                   rel;
  logic                   other_req;
  logic                   expire;

  assign own        = (state == OWN);
  assign owner_mask = owner ? 2'b10 : 2'b01;

  assign own_cyc = m_cyc_i[owner];
  assign own_stb = m_stb_i[owner];
  assign own_we  = m_we_i[owner];
  assign own_adr = owner ? m_adr_i[2*ADDR_WIDTH-1 -: ADDR_WIDTH] : m_adr_i[ADDR_WIDTH-1:0];
  assign own_dat = owner ? m_dat_i[2*DATA_WIDTH-1 -: DATA_WIDTH] : m_dat_i[DATA_WIDTH-1:0];
  assign own_sel = owner ? m_sel_i[2*SEL_WIDTH-1 -: SEL_WIDTH] : m_sel_i[SEL_WIDTH-1:0];

  // Release is the first owned cycle with the owner's CYC low; the slave CYC drops in the same cycle.
  assign rel       = own & ~own_cyc;
  assign other_req = owner ? req[0] : req[1];

  assign grant_o = own ? owner_mask : '0;
  assign s_cyc_o = own & own_cyc & ~expire;
  assign s_stb_o = own & own_stb & ~expire;
  assign s_we_o  = own & own_we;
  assign s_adr_o = own ? own_adr : '0;
  assign s_dat_o = own ? own_dat : '0;
  assign s_sel_o = own ? own_sel : '0;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = (own & s_ack_i) ? owner_mask : '0;
  assign m_err_o = (own & (s_err_i | expire)) ? owner_mask : '0;

`ifdef MD5_ARB_TIMEOUT_EN
  logic [NUM_MASTERS-1:0] blocked;
  logic                   stall;

  assign stall = own & own_cyc & own_stb & ~s_ack_i;

  md5_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .stall  (stall),
    .clear  (~own | s_ack_i | rel),
    .expire (expire)
  );

  // A timed-out master stays masked until its CYC has been seen low once.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      blocked <= '0;
    end else begin
      blocked <= m_cyc_i & (blocked | (expire ? owner_mask : '0));
    end
  end

  assign req = m_cyc_i & ~blocked;
`else
  assign expire = 1'b0;
  assign req    = m_cyc_i;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= OWN;
            owner <= (&req) ? ~last_owner : req[1];
          end
        end
        OWN: begin
          if (expire || rel) begin
            last_owner <= owner;
            if (!expire && other_req) begin
              owner <= ~owner;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_wb_arbiter.sv
// Directed bench for md5_wb_arbiter with a cycle-level reference model checked every cycle.
module tb_md5_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic [1:0]      m_cyc_i  = '0;
  logic [1:0]      m_stb_i  = '0;
  logic [1:0]      m_we_i   = '0;
  logic [2*AW-1:0] m_adr_i  = '0;
  logic [2*DW-1:0] m_dat_i  = '0;
  logic [2*SW-1:0] m_sel_i  = '0;
  logic [DW-1:0]   s_dat_i  = '0;
  logic            s_ack_i  = 1'b0;
  logic            s_err_i  = 1'b0;
  logic [DW-1:0]   m_dat_o;
  logic [1:0]      m_ack_o;
  logic [1:0]      m_err_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [1:0]      grant_o;

  int n_chk  = 0;
  int n_pass = 0;

  md5_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference model: owner is -1 when idle, else the index of the granted master.
  int        mo = -1;
  bit        ml = 1'b1;
  int        scnt = 0;
  bit  [1:0] blk = '0;
  bit        mvalid = 1'b0;
  bit  [1:0] req;
  bit        o_cyc, o_stb, exp_to, stalled;
  logic [1:0]    e_grant, e_ack, e_err;
  logic          e_cyc, e_stb, e_we;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;

  always @(negedge wb_clk_i) begin
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    o_cyc = 1'b0; o_stb = 1'b0; exp_to = 1'b0;
    if (mo >= 0) begin
      o_cyc = m_cyc_i[mo];
      o_stb = m_stb_i[mo];
`ifdef MD5_ARB_TIMEOUT_EN
      exp_to = o_cyc && o_stb && !s_ack_i && (scnt == TO - 1);
`endif
      e_grant[mo] = 1'b1;
      e_cyc = o_cyc && !exp_to;
      e_stb = o_stb && !exp_to;
      e_we  = m_we_i[mo];
      e_adr = m_adr_i[mo*AW +: AW];
      e_dat = m_dat_i[mo*DW +: DW];
      e_sel = m_sel_i[mo*SW +: SW];
      e_ack[mo] = s_ack_i;
      e_err[mo] = s_err_i || exp_to;
    end
    if (mvalid) begin
      chk("grant", 64'(grant_o), 64'(e_grant));
      chk("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
      chk("s_stb", 64'(s_stb_o), 64'(e_stb));
      chk("s_we",  64'(s_we_o),  64'(e_we));
      chk("s_adr", 64'(s_adr_o), 64'(e_adr));
      chk("s_dat", 64'(s_dat_o), 64'(e_dat));
      chk("s_sel", 64'(s_sel_o), 64'(e_sel));
      chk("m_ack", 64'(m_ack_o), 64'(e_ack));
      chk("m_err", 64'(m_err_o), 64'(e_err));
      chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
    end
    if (wb_rst_i) begin
      mo = -1; ml = 1'b1; scnt = 0; blk = '0; mvalid = 1'b1;
    end else begin
      req = m_cyc_i & ~blk;
      stalled = (mo >= 0) && o_cyc && o_stb && !s_ack_i;
      if (exp_to) blk[mo] = 1'b1;
      blk = blk & m_cyc_i;
      if (exp_to || mo < 0 || s_ack_i || !o_cyc) scnt = 0;
      else if (stalled) scnt = scnt + 1;
      if (mo < 0) begin
        if (req == 2'b11) mo = ml ? 0 : 1;
        else if (req == 2'b01) mo = 0;
        else if (req == 2'b10) mo = 1;
      end else if (exp_to) begin
        ml = mo[0]; mo = -1;
      end else if (!o_cyc) begin
        ml = mo[0];
        mo = req[1-mo] ? 1 - mo : -1;
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive_m(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[n] = cyc;
    m_stb_i[n] = stb;
    m_we_i[n]  = we;
    m_adr_i[n*AW +: AW] = adr;
    m_dat_i[n*DW +: DW] = dat;
    m_sel_i[n*SW +: SW] = cyc ? 4'hF : 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish within 100000 time units");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    // Reset, then simultaneous request on the first free cycle.
    wb_rst_i = 1'b1;
    tick(); tick();
    @(negedge wb_clk_i);
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    wb_rst_i = 1'b0;
    drive_m(0, 1, 1, 1, 32'h10, 32'hA0A0_0001);
    drive_m(1, 1, 1, 0, 32'h20, 32'hB0B0_0002);
    @(negedge wb_clk_i);
    chk("lat_grant", 64'(grant_o), 64'h0);
    tick();
    s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    chk("tie_grant", 64'(grant_o), 64'h1);
    chk("tie_adr",   64'(s_adr_o), 64'h10);
    chk("tie_ack",   64'(m_ack_o), 64'h1);
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i);
    chk("rel_cyc",   64'(s_cyc_o), 64'h0);
    tick();
    s_dat_i = 32'h6745_2301;
    s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    chk("hand_grant", 64'(grant_o), 64'h2);
    chk("rd_dat",     64'(m_dat_o), 64'h6745_2301);
    chk("rd_ack",     64'(m_ack_o), 64'h2);
    tick();
    s_ack_i = 1'b0;
    s_err_i = 1'b1;
    @(negedge wb_clk_i);
    chk("err_m1", 64'(m_err_o), 64'h2);
    tick();
    s_err_i = 1'b0;
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick();

    // 16-word burst by master 0 while master 1 keeps requesting.
    drive_m(0, 1, 1, 1, 32'h0, 32'h0);
    drive_m(1, 1, 1, 1, 32'h80, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive_m(0, 1, 1, 1, 32'(i * 4), 32'(i + 32'h100));
      s_ack_i = 1'b1;
      @(negedge wb_clk_i);
      chk("burst_adr", 64'(s_adr_o), 64'(i * 4));
      chk("burst_ack", 64'(m_ack_o), 64'h1);
      tick();
    end
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    @(negedge wb_clk_i);
    chk("burst_next", 64'(grant_o), 64'h2);
    tick();
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick();

    // Release with the other master idle, then immediate re-request.
    drive_m(0, 1, 1, 0, 32'h30, 32'h0);
    tick();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge wb_clk_i);
    chk("rr_hold", 64'(grant_o), 64'h1);
    tick();
    drive_m(0, 1, 1, 0, 32'h34, 32'h0);
    @(negedge wb_clk_i);
    chk("rr_gap", 64'(grant_o), 64'h0);
    tick();
    @(negedge wb_clk_i);
    chk("rr_again", 64'(grant_o), 64'h1);
    tick();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();

    // Abort before ACK, then a late ACK goes nowhere.
    drive_m(0, 1, 1, 0, 32'h44, 32'h0);
    tick();
    @(negedge wb_clk_i);
    chk("ab_stb", 64'(s_stb_o), 64'h1);
    tick();
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    chk("ab_late_ack", 64'(m_ack_o), 64'h0);
    tick();
    s_ack_i = 1'b0;

    // Stalled strobe with no ACK while master 1 waits.
    drive_m(0, 1, 1, 1, 32'h50, 32'h5);
    tick();
    drive_m(1, 1, 1, 0, 32'h99, 32'h0);
`ifdef MD5_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge wb_clk_i);
      chk("to_err", 64'(m_err_o), (k == TO) ? 64'h1 : 64'h0);
      chk("to_cyc", 64'(s_cyc_o), (k == TO) ? 64'h0 : 64'h1);
      tick();
    end
    @(negedge wb_clk_i);
    chk("to_idle", 64'(grant_o), 64'h0);
    tick();
    @(negedge wb_clk_i);
    chk("to_m1", 64'(grant_o), 64'h2);
    tick();
`else
    for (int k = 1; k <= 10; k++) begin
      @(negedge wb_clk_i);
      chk("st_err", 64'(m_err_o), 64'h0);
      chk("st_cyc", 64'(s_cyc_o), 64'h1);
      tick();
    end
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    @(negedge wb_clk_i);
    chk("st_m1", 64'(grant_o), 64'h2);
    tick();
`endif
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick(); tick();
    @(negedge wb_clk_i);
    chk("end_idle", 64'(grant_o), 64'h0);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
